// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if                                                       |
// | Fetch/data request ports and shared single-port RAM port bundle.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;

  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_stall;

  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  logic        bus_err;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_ren, mem_wen, mem_addr, mem_wdata,
           ram_rdata, ram_ready,
    output if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_en, ram_we, ram_addr, ram_wdata, bus_err
  );

  // Pipeline / RAM environment side
  modport master (
    output if_req, if_addr, mem_ren, mem_wen, mem_addr, mem_wdata,
           ram_rdata, ram_ready,
    input  if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_en, ram_we, ram_addr, ram_wdata, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Fetch/data arbiter for one shared RAM port, with fairness + timeout. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int                 c_cnt_w     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_last_busy = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [1:0]         c_streak_max = 2'd2;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_we;
  logic                 r_is_d;
  logic                 r_err;
  logic [c_cnt_w-1:0]   r_busy_cnt;
  logic [1:0]           r_streak;
  logic [31:0]          r_if_rdata;
  logic [31:0]          r_mem_rdata;

  logic                 w_data_req;
  logic                 w_busy;
  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_finish;
  logic                 w_timeout;
  logic [31:0]          w_capture;

  assign w_data_req = bus.mem_ren | bus.mem_wen;
  assign w_busy     = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_capture  = w_timeout ? 32'd0 : bus.ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        // A saturated data streak hands the next slot to a waiting fetch
        if (bus.if_req && (r_streak == c_streak_max)) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end else if (w_data_req) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (bus.if_req) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.ram_ready) begin
          w_finish = 1'b1;
          w_next   = DONE;
        end else if (r_busy_cnt == c_last_busy) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_is_d      <= 1'b0;
      r_err       <= 1'b0;
      r_busy_cnt  <= '0;
      r_streak    <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_grant_i || w_grant_d) begin
        r_busy_cnt <= '0;
        r_is_d     <= w_grant_d;
        r_addr     <= w_grant_d ? bus.mem_addr  : bus.if_addr;
        r_wdata    <= w_grant_d ? bus.mem_wdata : 32'd0;
        // Simultaneous ren/wen resolves to a write
        r_we       <= w_grant_d & bus.mem_wen;
        if (w_grant_i) begin
          r_streak <= '0;
        end else if (r_streak != c_streak_max) begin
          r_streak <= r_streak + 2'd1;
        end
      end else if (w_busy) begin
        r_busy_cnt <= r_busy_cnt + c_cnt_w'(1);
      end

      if (w_finish) begin
        r_err <= w_timeout;
        if (r_is_d) begin
          r_mem_rdata <= w_capture;
        end else begin
          r_if_rdata  <= w_capture;
        end
      end
    end
  end

  assign bus.ram_en    = w_busy;
  assign bus.ram_we    = (r_state == BUSY_D) && r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;

  assign bus.if_ack    = (r_state == DONE) && !r_is_d;
  assign bus.mem_ack   = (r_state == DONE) &&  r_is_d;
  assign bus.bus_err   = (r_state == DONE) &&  r_err;

  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;

  assign bus.if_stall  = bus.if_req & ~bus.if_ack;
  assign bus.mem_stall = w_data_req & ~bus.mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Vector table, directed corner sequences and a random model check.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_d;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          exp_lat;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];
  vec_t v;
  logic exp_grant_d [6];

  int   total = 0;
  int   bad   = 0;

  // Model state for the random phase
  int          m_kind;
  int          m_age;
  int          m_streak;
  bit          m_fin;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_last_if;
  logic [31:0] m_last_mem;
  bit          e_if_ack;
  bit          e_mem_ack;
  bit          e_en;
  bit          dreq;
  int          kk;

  int   m_at;
  int   i_at;
  int   g;
  bit   got_ack;
  bit   stall_ok;
  logic prev_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.ram_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           is_d  ren   wen   addr          wdata         rdata         dly lat we    err
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,  2, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        32'h1234_5678, 0,  2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3,  5, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0304, 32'hCAFE_0001, 32'h0000_00AA, 1,  3, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0,        32'hFFFF_FFFF, 99, 17, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0,        32'h8765_4321, 99, 17, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0504, 32'h0,        32'h1357_9BDF, 15, 17, 1'b0, 1'b0};
    exp_grant_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    idle_inputs();
    bus.if_addr   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ram_rdata = '0;
    repeat (2) next_cyc();
    smp();
    check("rst_ram_en",   32'(bus.ram_en),  32'd0);
    check("rst_ram_we",   32'(bus.ram_we),  32'd0);
    check("rst_acks",     32'({bus.if_ack, bus.mem_ack}), 32'd0);
    check("rst_bus_err",  32'(bus.bus_err), 32'd0);
    check("rst_if_rdata", bus.if_rdata,  32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    next_cyc();
    rst = 1'b0;

    // Single-transaction vectors
    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      next_cyc();
      if (v.is_d) begin
        bus.mem_ren = v.ren; bus.mem_wen = v.wen;
        bus.mem_addr = v.addr; bus.mem_wdata = v.wdata;
      end else begin
        bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      bus.ram_ready = 1'b0;
      bus.ram_rdata = v.rdata;
      smp();
      check("vec_stall_req", 32'(v.is_d ? bus.mem_stall : bus.if_stall), 32'd1);
      got_ack = 1'b0;
      for (int c = 1; c <= 40 && !got_ack; c++) begin
        next_cyc();
        bus.ram_ready = (c > v.delay);
        smp();
        if (c == 1) begin
          check("vec_grant_en",   32'(bus.ram_en), 32'd1);
          check("vec_grant_addr", bus.ram_addr, v.addr);
          check("vec_grant_we",   32'(bus.ram_we), 32'(v.exp_we));
          if (v.exp_we) check("vec_grant_wdata", bus.ram_wdata, v.wdata);
        end
        if (bus.if_ack || bus.mem_ack) begin
          got_ack = 1'b1;
          check("vec_ack_lat",  32'(c), 32'(v.exp_lat));
          check("vec_ack_src",  32'({bus.if_ack, bus.mem_ack}), v.is_d ? 32'd1 : 32'd2);
          check("vec_ack_rdata", v.is_d ? bus.mem_rdata : bus.if_rdata,
                v.exp_err ? 32'd0 : v.rdata);
          check("vec_bus_err",  32'(bus.bus_err), 32'(v.exp_err));
          check("vec_stall_ack", 32'(v.is_d ? bus.mem_stall : bus.if_stall), 32'd0);
        end
      end
      if (!got_ack) begin
        total++; bad++;
        $display("FAIL vec_no_ack: vector %0d got no ack within 40 cycles, required ack", k);
      end
      next_cyc();
      idle_inputs();
      smp();
      check("vec_idle_after", 32'(bus.ram_en), 32'd0);
    end

    // Simultaneous fetch and load: data first, fetch stall held until its ack
    next_cyc();
    bus.if_req = 1'b1;  bus.if_addr  = 32'h0000_0400;
    bus.mem_ren = 1'b1; bus.mem_addr = 32'h0000_0500;
    bus.ram_ready = 1'b1; bus.ram_rdata = 32'h55AA_55AA;
    smp();
    stall_ok = bus.if_stall;
    m_at = -1; i_at = -1;
    for (int c = 1; c <= 20 && i_at < 0; c++) begin
      next_cyc();
      if (m_at >= 0) begin
        bus.mem_ren = 1'b0;
        bus.ram_rdata = 32'h6666_0001;
      end
      smp();
      if (bus.mem_ack && m_at < 0) begin
        m_at = c;
        check("both_mem_rdata", bus.mem_rdata, 32'h55AA_55AA);
      end
      if (bus.if_ack) begin
        i_at = c;
        check("both_if_rdata", bus.if_rdata, 32'h6666_0001);
        check("both_if_stall_ack", 32'(bus.if_stall), 32'd0);
      end else if (!bus.if_stall) begin
        stall_ok = 1'b0;
      end
    end
    check("both_mem_ack_cycle", 32'(m_at), 32'd2);
    check("both_if_ack_cycle",  32'(i_at), 32'd5);
    check("both_if_stall_held", 32'(stall_ok), 32'd1);
    next_cyc();
    idle_inputs();

    // Continuous store stream plus fetch: fairness order D,D,I,D,D,I
    next_cyc();
    bus.mem_wen = 1'b1; bus.mem_addr = 32'h0000_0600; bus.mem_wdata = 32'h0000_0077;
    bus.if_req  = 1'b1; bus.if_addr  = 32'h0000_0700;
    bus.ram_ready = 1'b1;
    g = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 40 && g < 6; c++) begin
      if (c > 0) next_cyc();
      smp();
      if (bus.ram_en && !prev_en) begin
        check("fair_addr", bus.ram_addr, exp_grant_d[g] ? 32'h0000_0600 : 32'h0000_0700);
        check("fair_we",   32'(bus.ram_we), 32'(exp_grant_d[g]));
        g++;
      end
      prev_en = bus.ram_en;
    end
    if (g < 6) begin
      total++; bad++;
      $display("FAIL fair_grants: got %0d grants, required 6", g);
    end
    next_cyc();
    idle_inputs();
    repeat (2) next_cyc();

    // Reset while BUSY_D
    bus.mem_ren = 1'b1; bus.mem_addr = 32'h0000_0800; bus.ram_ready = 1'b0;
    next_cyc();
    smp();
    check("rstmid_busy_en", 32'(bus.ram_en), 32'd1);
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    bus.mem_ren = 1'b0;
    smp();
    check("rstmid_en_drop", 32'(bus.ram_en), 32'd0);
    check("rstmid_no_ack",  32'({bus.if_ack, bus.mem_ack, bus.bus_err}), 32'd0);
    check("rstmid_mem_rdata", bus.mem_rdata, 32'd0);
    check("rstmid_if_rdata",  bus.if_rdata,  32'd0);
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      smp();
      check("rstmid_quiet", 32'({bus.ram_en, bus.if_ack, bus.mem_ack}), 32'd0);
    end
    next_cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0900;
    bus.ram_ready = 1'b1; bus.ram_rdata = 32'h1111_2222;
    next_cyc();
    smp();
    check("rstmid_fetch_addr", bus.ram_addr, 32'h0000_0900);
    check("rstmid_fetch_en",   32'(bus.ram_en), 32'd1);
    next_cyc();
    smp();
    check("rstmid_fetch_ack",   32'(bus.if_ack), 32'd1);
    check("rstmid_fetch_rdata", bus.if_rdata, 32'h1111_2222);
    next_cyc();
    idle_inputs();

    // Load dropped mid-access still completes, no re-grant
    next_cyc();
    bus.mem_ren = 1'b1; bus.mem_addr = 32'h0000_0A00;
    bus.ram_ready = 1'b0; bus.ram_rdata = 32'h3C3C_3C3C;
    next_cyc();
    smp();
    check("drop_en", 32'(bus.ram_en), 32'd1);
    next_cyc();
    bus.mem_ren = 1'b0;
    smp();
    check("drop_stall", 32'(bus.mem_stall), 32'd0);
    next_cyc();
    bus.ram_ready = 1'b1;
    next_cyc();
    bus.ram_ready = 1'b0;
    smp();
    check("drop_ack",   32'(bus.mem_ack), 32'd1);
    check("drop_rdata", bus.mem_rdata, 32'h3C3C_3C3C);
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      smp();
      check("drop_no_regrant", 32'(bus.ram_en), 32'd0);
    end

    // Random traffic against a transaction-level model
    next_cyc();
    rst = 1'b1;
    idle_inputs();
    next_cyc();
    rst = 1'b0;
    m_kind = 0; m_age = 0; m_streak = 0; m_fin = 0; m_err = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_last_if = '0; m_last_mem = '0;
    e_if_ack = 0; e_mem_ack = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cyc();
      if (e_if_ack) bus.if_req = 1'b0;
      else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = $urandom;
      end
      if (e_mem_ack) begin
        bus.mem_ren = 1'b0; bus.mem_wen = 1'b0;
      end else if (!(bus.mem_ren | bus.mem_wen) && $urandom_range(0, 2) == 0) begin
        kk = $urandom_range(1, 3);
        bus.mem_ren = kk[0]; bus.mem_wen = kk[1];
        bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
      end
      bus.ram_ready = ((cyc % 250) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.ram_rdata = $urandom;
      smp();

      e_if_ack  = m_fin && (m_kind == 1);
      e_mem_ack = m_fin && (m_kind == 2);
      e_en      = (m_kind != 0) && !m_fin;
      check("rnd_ram_en", 32'(bus.ram_en), 32'(e_en));
      if (e_en) begin
        check("rnd_ram_addr", bus.ram_addr, m_addr);
        check("rnd_ram_we",   32'(bus.ram_we), 32'((m_kind == 2) && m_we));
        if ((m_kind == 2) && m_we) check("rnd_ram_wdata", bus.ram_wdata, m_wdata);
      end
      check("rnd_acks",      32'({bus.if_ack, bus.mem_ack}), 32'({e_if_ack, e_mem_ack}));
      check("rnd_bus_err",   32'(bus.bus_err), 32'(m_fin && m_err));
      check("rnd_if_rdata",  bus.if_rdata,  m_last_if);
      check("rnd_mem_rdata", bus.mem_rdata, m_last_mem);
      check("rnd_stalls", 32'({bus.if_stall, bus.mem_stall}),
            32'({bus.if_req & ~e_if_ack, (bus.mem_ren | bus.mem_wen) & ~e_mem_ack}));

      if (m_fin) begin
        m_kind = 0;
        m_fin  = 0;
      end else if (m_kind != 0) begin
        m_age++;
        if (bus.ram_ready || m_age == TO) begin
          m_fin = 1;
          m_err = !bus.ram_ready;
          if (m_kind == 1) m_last_if  = bus.ram_ready ? bus.ram_rdata : 32'd0;
          else             m_last_mem = bus.ram_ready ? bus.ram_rdata : 32'd0;
        end
      end else begin
        dreq = bus.mem_ren | bus.mem_wen;
        m_age = 0;
        if (bus.if_req && (m_streak >= 2 || !dreq)) begin
          m_kind = 1; m_streak = 0; m_addr = bus.if_addr; m_we = 0;
        end else if (dreq) begin
          m_kind = 2; m_streak++; m_addr = bus.mem_addr;
          m_wdata = bus.mem_wdata; m_we = bus.mem_wen;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
